// File: rtl/silife_gen_ctrl_if.sv
// Command channel of the silife generation controller: one command plus the
// free-run period, moved across a valid/ready handshake.
interface silife_gen_ctrl_if #(
    parameter int PERIOD_WIDTH = 16
);
    // A command transfers on a rising edge where cmd_valid && cmd_ready. The
    // source keeps cmd_valid, cmd and period stable until that edge. The
    // controller never stores a command it has not accepted.
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [1:0]              cmd;
    logic [PERIOD_WIDTH-1:0] period;

    modport master (
        output cmd_valid,
        output cmd,
        output period,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd,
        input  period,
        output cmd_ready
    );
endinterface

// File: rtl/silife_gen_ctrl.sv
// Generation controller for the silife cell array: turns stop/run/step/clear commands into
// one-cycle cell_enable / cell_reset strobes. Optional generation counter: SILIFE_GEN_COUNT_EN.
module silife_gen_ctrl #(
    parameter int PERIOD_WIDTH = 16,
    parameter int GEN_WIDTH    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    silife_gen_ctrl_if.slave     cmd_if,
    output logic                 busy_o,
    output logic                 cell_enable_o,
    output logic                 cell_reset_o,
    output logic [GEN_WIDTH-1:0] generation_o,
    output logic                 gen_wrap_o,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

    localparam logic [1:0] CMD_STOP  = 2'd0;
    localparam logic [1:0] CMD_RUN   = 2'd1;
    localparam logic [1:0] CMD_STEP  = 2'd2;
    localparam logic [1:0] CMD_CLEAR = 2'd3;

    state_e                  state_q, state_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic                    enable_q, enable_d;
    logic                    clear_q, clear_d;
    logic                    accept;
    logic [PERIOD_WIDTH-1:0] period_w;

    assign period_w         = cmd_if.period;
    assign cmd_if.cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign accept           = cmd_if.cmd_valid && cmd_if.cmd_ready;

    // cnt_q holds the idle edges still to pass before the next pulse-issuing edge,
    // so a (re)start loads period-1 and period=0 pulses on the accepting edge itself.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        enable_d = 1'b0;
        clear_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (cmd_if.cmd)
                        CMD_RUN: begin
                            state_d = ST_RUN;
                            if (period_w == '0) begin
                                enable_d = 1'b1;
                                cnt_d    = '0;
                            end else begin
                                cnt_d = period_w - PERIOD_WIDTH'(1);
                            end
                        end
                        CMD_STEP: begin
                            state_d  = ST_STEP;
                            enable_d = 1'b1;
                        end
                        CMD_CLEAR: begin
                            state_d = ST_CLEAR;
                            clear_d = 1'b1;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_RUN: begin
                if (accept && cmd_if.cmd == CMD_STOP) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (accept && cmd_if.cmd == CMD_CLEAR) begin
                    state_d = ST_CLEAR;
                    clear_d = 1'b1;
                    cnt_d   = '0;
                end else if (accept && cmd_if.cmd == CMD_RUN) begin
                    if (period_w == '0) begin
                        enable_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = period_w - PERIOD_WIDTH'(1);
                    end
                end else if (cnt_q == '0) begin
                    // An accepted STEP lands here too: it is dropped and counting goes on.
                    enable_d = 1'b1;
                    cnt_d    = period_w;
                end else begin
                    cnt_d = cnt_q - PERIOD_WIDTH'(1);
                end
            end
            ST_STEP:  state_d = ST_IDLE;
            ST_CLEAR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            enable_q <= 1'b0;
            clear_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            enable_q <= enable_d;
            clear_q  <= clear_d;
        end
    end

    assign cell_enable_o = enable_q;
    assign cell_reset_o  = clear_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign state_o       = state_q;

`ifdef SILIFE_GEN_COUNT_EN
    logic [GEN_WIDTH-1:0] gen_q, gen_d;
    logic                 wrap_q, wrap_d;

    // Counts on the same edge that registers the cell_enable pulse.
    always_comb begin
        gen_d  = gen_q;
        wrap_d = 1'b0;
        if (clear_d) begin
            gen_d = '0;
        end else if (enable_d) begin
            gen_d  = gen_q + GEN_WIDTH'(1);
            wrap_d = &gen_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gen_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            gen_q  <= gen_d;
            wrap_q <= wrap_d;
        end
    end

    assign generation_o = gen_q;
    assign gen_wrap_o   = wrap_q;
`else
    assign generation_o = '0;
    assign gen_wrap_o   = 1'b0;
`endif

endmodule

// File: tb/tb_silife_gen_ctrl.sv
// Bench for silife_gen_ctrl: directed scenarios then random commands, every cycle checked
// against an arithmetic model of the pulse schedule (GEN_WIDTH=4 to reach the wrap).
module tb_silife_gen_ctrl;

    localparam int PW = 16;
    localparam int GW = 4;

    localparam logic [1:0] C_STOP  = 2'd0;
    localparam logic [1:0] C_RUN   = 2'd1;
    localparam logic [1:0] C_STEP  = 2'd2;
    localparam logic [1:0] C_CLEAR = 2'd3;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STEP  = 2;
    localparam int M_CLEAR = 3;

    logic          clk;
    logic          rst;
    logic          busy;
    logic          cell_enable;
    logic          cell_reset;
    logic [GW-1:0] generation;
    logic          gen_wrap;
    logic [1:0]    state_dbg;

    silife_gen_ctrl_if #(.PERIOD_WIDTH(PW)) cmd_if ();

    silife_gen_ctrl #(
        .PERIOD_WIDTH (PW),
        .GEN_WIDTH    (GW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cmd_if        (cmd_if),
        .busy_o        (busy),
        .cell_enable_o (cell_enable),
        .cell_reset_o  (cell_reset),
        .generation_o  (generation),
        .gen_wrap_o    (gen_wrap),
        .state_o       (state_dbg)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: mode plus run start edge / period; pulses follow from arithmetic.
    int n_vec;
    int n_err;
    int mode;
    int edge_n;
    int run_k;
    int run_p;
    int exp_gen;
    bit exp_en;
    bit exp_rst;
    bit exp_wrap;

    function automatic bit run_pulse(input int e);
        int d;
        d = e - run_k;
        return (d >= run_p) && (((d - run_p) % (run_p + 1)) == 0);
    endfunction

    function automatic bit model_ready();
        return (mode == M_IDLE) || (mode == M_RUN);
    endfunction

    task automatic model_edge(input bit v, input logic [1:0] c, input int p);
        bit acc;
        acc      = v && model_ready();
        exp_en   = 1'b0;
        exp_rst  = 1'b0;
        exp_wrap = 1'b0;
        if (acc) begin
            case (c)
                C_STOP: mode = M_IDLE;
                C_RUN: begin
                    mode   = M_RUN;
                    run_k  = edge_n;
                    run_p  = p;
                    exp_en = run_pulse(edge_n);
                end
                C_STEP: begin
                    if (mode == M_IDLE) begin
                        mode   = M_STEP;
                        exp_en = 1'b1;
                    end else begin
                        exp_en = run_pulse(edge_n);
                    end
                end
                default: begin
                    mode    = M_CLEAR;
                    exp_rst = 1'b1;
                    exp_gen = 0;
                end
            endcase
        end else if (mode == M_RUN) begin
            exp_en = run_pulse(edge_n);
        end else begin
            mode = M_IDLE;
        end
`ifdef SILIFE_GEN_COUNT_EN
        if (exp_en) begin
            exp_gen = (exp_gen + 1) % (1 << GW);
            exp_wrap = (exp_gen == 0);
        end
`endif
        edge_n++;
    endtask

    task automatic model_reset();
        mode     = M_IDLE;
        exp_gen  = 0;
        exp_en   = 1'b0;
        exp_rst  = 1'b0;
        exp_wrap = 1'b0;
    endtask

    // Scoreboard
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("cell_enable", cell_enable, exp_en);
        chk("cell_reset", cell_reset, exp_rst);
        chk("busy", busy, (mode != M_IDLE));
        chk("cmd_ready", cmd_if.cmd_ready, model_ready());
        chk("generation", generation, exp_gen);
        chk("gen_wrap", gen_wrap, exp_wrap);
        chk("en_rst_exclusive", cell_enable & cell_reset, 1'b0);
    endtask

    task automatic check_reset_vals();
        chk("rst_cell_enable", cell_enable, 1'b0);
        chk("rst_cell_reset", cell_reset, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cmd_ready", cmd_if.cmd_ready, 1'b1);
        chk("rst_generation", generation, '0);
        chk("rst_gen_wrap", gen_wrap, 1'b0);
    endtask

    // Driver tasks: inputs change at the negedge, outputs are checked at the next negedge.
    task automatic cyc(input bit v, input logic [1:0] c, input int p);
        cmd_if.cmd_valid = v;
        cmd_if.cmd       = c;
        cmd_if.period    = PW'(p);
        @(posedge clk);
        model_edge(v, c, p);
        @(negedge clk);
        check_all();
    endtask

    task automatic send(input logic [1:0] c, input int p);
        bit rdy;
        int tries;
        tries = 0;
        do begin
            rdy = cmd_if.cmd_ready;
            cyc(1'b1, c, p);
            tries++;
        end while (!rdy && tries < 8);
        if (!rdy) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n, input int p);
        for (int i = 0; i < n; i++) cyc(1'b0, C_STOP, p);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cur_p;
        bit v;
        logic [1:0] c;
        n_vec  = 0;
        n_err  = 0;
        edge_n = 0;
        run_k  = 0;
        run_p  = 0;
        model_reset();
        rst              = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd       = C_STOP;
        cmd_if.period    = '0;
        #2;
        check_reset_vals();
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        idle(2, 0);

        // Single STEP
        send(C_STEP, 0);
        idle(3, 0);

        // Free run, period 3, then STOP
        send(C_RUN, 3);
        idle(20, 3);
        send(C_STOP, 3);
        idle(4, 3);

        // Period 0 runs every cycle; STOP on a pulse edge
        send(C_RUN, 0);
        idle(5, 0);
        send(C_STOP, 0);
        idle(3, 0);

        // CLEAR during RUN, then STEP held off by CLEAR and taken in IDLE
        send(C_RUN, 2);
        idle(4, 2);
        send(C_CLEAR, 2);
        send(C_STEP, 2);
        idle(2, 2);
        send(C_CLEAR, 0);
        send(C_STEP, 0);
        idle(2, 0);

        // STEP during RUN is dropped; RUN during RUN restarts
        send(C_RUN, 4);
        idle(3, 4);
        send(C_STEP, 4);
        idle(2, 4);
        send(C_RUN, 1);
        idle(6, 1);
        send(C_STOP, 1);

        // Sixteen STEPs from a cleared counter cover the wrap
        send(C_CLEAR, 0);
        for (int i = 0; i < 16; i++) begin
            send(C_STEP, 0);
            cyc(1'b0, C_STOP, 0);
        end
        idle(2, 0);

        // Asynchronous reset in the middle of a period-0 run
        send(C_RUN, 0);
        idle(3, 0);
        #1 rst = 1'b1;
        #1 check_reset_vals();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd       = C_STEP;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        rst              = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        model_reset();
        idle(2, 0);
        send(C_STEP, 0);
        idle(2, 0);

        // Random commands; period only changes together with a RUN request
        cur_p = 0;
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 2) != 0);
            c = 2'($urandom_range(0, 3));
            if (c == C_CLEAR && $urandom_range(0, 3) != 0) c = C_STEP;
            if (v && c == C_RUN) cur_p = $urandom_range(0, 5);
            cyc(v, c, cur_p);
        end
        idle(3, cur_p);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
